threewire_cmd_queue: RTL

THREEWIRE_CMD_QUEUE -- requirements
Module: threewire_cmd_queue

---
 rtl/threewire_cmd_queue.sv | 138 +++++++++++++
 1 files changed

// File: rtl/threewire_cmd_queue.sv
// Command queue in front of a three-wire register master: buffers read/write
// commands in a small FIFO, issues them one at a time and returns read data in order.
module threewire_cmd_queue #(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_BITS  = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_cmd_valid,
  output logic                  out_cmd_ready,
  input  logic                  in_cmd_wr,
  input  logic [ADDR_BITS-1:0]  in_cmd_addr,
  input  logic [DATA_BITS-1:0]  in_cmd_data,
  output logic                  out_rsp_valid,
  input  logic                  in_rsp_ready,
  output logic [ADDR_BITS-1:0]  out_rsp_addr,
  output logic [DATA_BITS-1:0]  out_rsp_data,
  output logic                  out_tw_start,
  output logic                  out_tw_mode_wr,
  output logic [ADDR_BITS-1:0]  out_tw_addr,
  output logic [DATA_BITS-1:0]  out_tw_wr_data,
  input  logic [DATA_BITS-1:0]  in_tw_rd_data,
  input  logic                  in_tw_busy,
  output logic [DEPTH_LOG2:0]   out_level
);

  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int ENTRY_BITS = 1 + ADDR_BITS + DATA_BITS;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_RESP      = 2'd3;

  logic [ENTRY_BITS-1:0] fifo_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [1:0]            state_q, state_d;
  logic                  tw_mode_wr_q, tw_mode_wr_d;
  logic [ADDR_BITS-1:0]  tw_addr_q, tw_addr_d;
  logic [DATA_BITS-1:0]  tw_wr_data_q, tw_wr_data_d;
  logic [ADDR_BITS-1:0]  rsp_addr_q, rsp_addr_d;
  logic [DATA_BITS-1:0]  rsp_data_q, rsp_data_d;
  logic                  push, pop;

  // Ready looks only at the registered level, so a full queue refuses a push
  // even in the cycle the FSM pops.
  assign out_cmd_ready = (level_q != FULL_LEVEL);
  assign push          = in_cmd_valid && out_cmd_ready;

  // NOTE: the command storage has no reset; the pointers and level define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge in_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {in_cmd_wr, in_cmd_addr, in_cmd_data};
  end

  always_comb begin
    // NOTE: every always_comb output is given a default first so no path infers a latch.
    state_d      = state_q;
    tw_mode_wr_d = tw_mode_wr_q;
    tw_addr_d    = tw_addr_q;
    tw_wr_data_d = tw_wr_data_q;
    rsp_addr_d   = rsp_addr_q;
    rsp_data_d   = rsp_data_q;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (level_q != '0) begin
          pop = 1'b1;
          {tw_mode_wr_d, tw_addr_d, tw_wr_data_d} = fifo_mem[rd_ptr_q];
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (in_tw_busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!in_tw_busy) begin
          if (tw_mode_wr_q) begin
            state_d = ST_IDLE;
          end else begin
            rsp_addr_d = tw_addr_q;
            rsp_data_d = in_tw_rd_data;
            state_d    = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (in_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      state_q      <= ST_IDLE;
      tw_mode_wr_q <= 1'b0;
      tw_addr_q    <= '0;
      tw_wr_data_q <= '0;
      rsp_addr_q   <= '0;
      rsp_data_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q      <= level_d;
      state_q      <= state_d;
      tw_mode_wr_q <= tw_mode_wr_d;
      tw_addr_q    <= tw_addr_d;
      tw_wr_data_q <= tw_wr_data_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign out_tw_start   = (state_q == ST_START);
  assign out_rsp_valid  = (state_q == ST_RESP);
  assign out_tw_mode_wr = tw_mode_wr_q;
  assign out_tw_addr    = tw_addr_q;
  assign out_tw_wr_data = tw_wr_data_q;
  assign out_rsp_addr   = rsp_addr_q;
  assign out_rsp_data   = rsp_data_q;
  assign out_level      = level_q;

endmodule
